sa_phase_sequencer: RTL and testbench
=====================================

# sa_phase_sequencer

Top-level phase sequencer for the systolic array. It drives the array and its controller through reset, ROM-signal fetch, weight load, ready and operate phases for a programmable number of tiles. It produces the `rst_o`, `load_o`, `ready_o` and `start_op_o` phase strobes and the ROM-signal read address and load enables consumed by `SA_controller` and the weight/feature buffers. Feature starvation stalls the operate phase without losing count.

## Interface
- `SIG_ADDRS_WIDTH`, default 10: ROM-signal address width.
- `CNT_WIDTH`, default 16: width of the load and operate cycle counters.
- `TILE_WIDTH`, default 10: width of the tile count.
- `RST_CYCLES`, default 2: cycles `rst_o` is held at the start of a job (≥1).

Ports (clock and reset first):
- `clk_i`  in  1  single clock, rising edge.
- `general_rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  job request, sampled in IDLE only.
- `abort_i`  in  1  synchronous abort, any non-IDLE state.
- `num_tiles_i`  in  TILE_WIDTH  tiles per job.
- `rom_base_i`  in  SIG_ADDRS_WIDTH  ROM address of tile 0.
- `load_cycles_i`  in  CNT_WIDTH  weight-load cycles per tile.
- `op_cycles_i`  in  CNT_WIDTH  valid operate cycles per tile.
- `feat_valid_i`  in  1  feature word available this cycle.
- `rst_o`  out  1  array/controller reset phase.
- `load_o`  out  1  weight-load phase.
- `ready_o`  out  1  one-cycle ready phase.
- `start_op_o`  out  1  operate phase.
- `rd_rom_signals_ld_o`  out  1  latch ROM signal word.
- `rd_weight_ld_o`  out  1  read weight buffer.
- `rd_feature_ld_o`  out  1  read feature buffer.
- `addrs_rom_signal_o`  out  SIG_ADDRS_WIDTH  ROM-signal address.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle job-complete pulse.

## Operation
- States: IDLE, RESET, FETCH, LOAD, READY, RUN, DONE.
- IDLE + `start_i` → RESET. This transition latches `num_tiles_i`, `load_cycles_i` and `op_cycles_i`, loads the address register with `rom_base_i`, and clears the tile counter.
- RESET lasts RST_CYCLES cycles with `rst_o`=1.
  - If the latched tile count is 0, RESET → DONE.
  - Otherwise RESET → FETCH.
- FETCH lasts 1 cycle with `rd_rom_signals_ld_o`=1, then → LOAD.
- LOAD has `load_o`=`rd_weight_ld_o`=1 for L cycles, where L = max(`load_cycles_i`,1). Then → READY.
- READY lasts 1 cycle with `ready_o`=1, then → RUN.
- RUN:
  - `start_op_o`=1 throughout.
  - `rd_feature_ld_o` = `feat_valid_i` (combinational).
  - The operate counter advances only on cycles with `feat_valid_i`=1.
  - After P valid cycles, where P = max(`op_cycles_i`,1), the tile is finished: the tile counter increments and the address register increments (modulo 2^SIG_ADDRS_WIDTH).
  - Next state is FETCH if tiles remain, else DONE.
- DONE lasts 1 cycle with `done_o`=1, then → IDLE.
- `abort_i` in any non-IDLE state takes priority over every other transition. Next cycle is RESET for 1 cycle, then IDLE, with no `done_o`.
- `start_i` outside IDLE is ignored. Config inputs are don't-care after being latched.
- Output decode:
  - All phase outputs are decoded from the registered state.
  - `rd_feature_ld_o` is the only output with an input dependency.
  - At most one of `rst_o`/`load_o`/`ready_o`/`start_op_o` is high at any time.
- `addrs_rom_signal_o` holds its last value in IDLE.

## Timing
- On `general_rst_i`:
  - State = IDLE.
  - All outputs 0, including `addrs_rom_signal_o`.
  - All counters cleared.
  - This applies immediately, including mid-job.
- `start_i` sampled at edge 0 gives:
  - RESET in cycles 1..RST_CYCLES.
  - FETCH in cycle RST_CYCLES+1.
- Per-tile duration with no stalls is L+P+2 cycles.
- `done_o` appears in cycle RST_CYCLES + T·(L+P+2) + 1, plus the number of stall cycles.
- When the last valid RUN cycle coincides with `abort_i`, abort wins: no tile increment and no `done_o`.
- Address wrap: with base 2^SIG_ADDRS_WIDTH−1, the second tile reads address 0.
- The next job may start in the cycle after DONE, i.e. the first IDLE cycle.

## Structure
- Put in a shared package `sa_ctrl_pkg`:
  - state enum `sa_phase_e` (IDLE, RESET, FETCH, LOAD, READY, RUN, DONE);
  - phase-strobe struct type.
- Single module. No sub-module is needed except an optional `sa_phase_counter` (load/clear/enable down-counter), instantiated for the RESET, LOAD and RUN phase counts.

## Test plan
- RST_CYCLES=2, base=5, T=2, L=3, P=4, `feat_valid_i`=1, start at edge 0. Expected cycle by cycle:
  - RESET cycles 1–2; FETCH cycles 3 and 12 with address 5 then 6;
  - `load_o` cycles 4–6 and 13–15; `ready_o` cycles 7 and 16;
  - `start_op_o` cycles 8–11 and 17–20; `done_o` cycle 21.
- Same config with `feat_valid_i` low for 3 cycles inside the first RUN → `done_o` at cycle 24. `rd_feature_ld_o` is high on exactly 8 cycles.
- `num_tiles_i`=0 → `rst_o` cycles 1–2, `done_o` cycle 3. No FETCH, LOAD or RUN.
- `abort_i` in cycle 5 (LOAD) → `rst_o` in cycle 6, IDLE in cycle 7, `done_o` never asserted, `busy_o` low from cycle 7.
- `general_rst_i` pulsed mid-RUN → all outputs 0 immediately. A new start afterwards begins at address `rom_base_i`.
- L=0, P=0, base=1023, T=2 → each phase lasts 1 cycle; the second FETCH address is 0.

Source files
------------

// File: rtl/sa_ctrl_pkg.sv
// ============================================================================
// Module      : sa_ctrl_pkg
// Description : Shared phase enum, strobe bundle and state decode for the
//               systolic-array phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    READY = 3'd4,
    RUN   = 3'd5,
    DONE  = 3'd6
  } sa_phase_e;

  typedef struct packed {
    logic rst;
    logic load;
    logic ready;
    logic start_op;
    logic rom_ld;
    logic weight_ld;
    logic busy;
    logic done;
  } sa_strobe_t;

  // Every phase strobe is a pure function of the registered state.
  function automatic sa_strobe_t phase_strobes(input sa_phase_e ph);
    sa_strobe_t s;
    s      = '0;
    s.busy = (ph != IDLE);
    unique case (ph)
      RESET:   s.rst = 1'b1;
      FETCH:   s.rom_ld = 1'b1;
      LOAD: begin
        s.load      = 1'b1;
        s.weight_ld = 1'b1;
      end
      READY:   s.ready = 1'b1;
      RUN:     s.start_op = 1'b1;
      DONE:    s.done = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_phase_counter.sv
// ============================================================================
// Module      : sa_phase_counter
// Description : Load/enable down-counter flagging the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_phase_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             general_rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (en_i && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero_o = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sa_phase_sequencer.sv
// ============================================================================
// Module      : sa_phase_sequencer
// Description : Sequences reset/fetch/load/ready/operate phases of the
//               systolic array over a programmable number of tiles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_phase_sequencer
  import sa_ctrl_pkg::*;
#(
  parameter int SIG_ADDRS_WIDTH = 10,
  parameter int CNT_WIDTH       = 16,
  parameter int TILE_WIDTH      = 10,
  parameter int RST_CYCLES      = 2
) (
  input  logic                       clk_i,
  input  logic                       general_rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [TILE_WIDTH-1:0]      num_tiles_i,
  input  logic [SIG_ADDRS_WIDTH-1:0] rom_base_i,
  input  logic [CNT_WIDTH-1:0]       load_cycles_i,
  input  logic [CNT_WIDTH-1:0]       op_cycles_i,
  input  logic                       feat_valid_i,
  output logic                       rst_o,
  output logic                       load_o,
  output logic                       ready_o,
  output logic                       start_op_o,
  output logic                       rd_rom_signals_ld_o,
  output logic                       rd_weight_ld_o,
  output logic                       rd_feature_ld_o,
  output logic [SIG_ADDRS_WIDTH-1:0] addrs_rom_signal_o,
  output logic                       busy_o,
  output logic                       done_o
);

  sa_phase_e                  r_state;
  logic                       r_abort;
  logic [TILE_WIDTH-1:0]      r_num_tiles;
  logic [TILE_WIDTH-1:0]      r_tile;
  logic [CNT_WIDTH-1:0]       r_load_m1;
  logic [CNT_WIDTH-1:0]       r_op_m1;
  logic [SIG_ADDRS_WIDTH-1:0] r_addr;

  logic                       w_abort;
  logic                       w_cnt_load;
  logic                       w_cnt_en;
  logic [CNT_WIDTH-1:0]       w_cnt_val;
  logic                       w_cnt_zero;
  logic [TILE_WIDTH-1:0]      w_tile_next;
  sa_strobe_t                 w_strb;

  assign w_abort     = abort_i && (r_state != IDLE);
  assign w_tile_next = r_tile + 1'b1;

  // Phase lengths are held as (length-1) so zero on the counter marks the last cycle.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_val  = '0;
    if (w_abort) begin
      w_cnt_load = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_load = start_i;
          w_cnt_val  = CNT_WIDTH'(RST_CYCLES - 1);
        end
        RESET, LOAD: w_cnt_en = 1'b1;
        FETCH: begin
          w_cnt_load = 1'b1;
          w_cnt_val  = r_load_m1;
        end
        READY: begin
          w_cnt_load = 1'b1;
          w_cnt_val  = r_op_m1;
        end
        RUN:     w_cnt_en = feat_valid_i;
        default: ;
      endcase
    end
  end

  sa_phase_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_phase_cnt (
    .clk_i         (clk_i),
    .general_rst_i (general_rst_i),
    .load_i        (w_cnt_load),
    .load_val_i    (w_cnt_val),
    .en_i          (w_cnt_en),
    .zero_o        (w_cnt_zero)
  );

  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      r_state     <= IDLE;
      r_abort     <= 1'b0;
      r_num_tiles <= '0;
      r_tile      <= '0;
      r_load_m1   <= '0;
      r_op_m1     <= '0;
      r_addr      <= '0;
    end else if (w_abort) begin
      r_state <= RESET;
      r_abort <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state     <= RESET;
            r_abort     <= 1'b0;
            r_num_tiles <= num_tiles_i;
            r_load_m1   <= (load_cycles_i == '0) ? '0 : load_cycles_i - 1'b1;
            r_op_m1     <= (op_cycles_i == '0) ? '0 : op_cycles_i - 1'b1;
            r_addr      <= rom_base_i;
            r_tile      <= '0;
          end
        end
        RESET: begin
          if (w_cnt_zero) begin
            if (r_abort) begin
              r_state <= IDLE;
              r_abort <= 1'b0;
            end else if (r_num_tiles == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        FETCH: r_state <= LOAD;
        LOAD:  if (w_cnt_zero) r_state <= READY;
        READY: r_state <= RUN;
        RUN: begin
          if (feat_valid_i && w_cnt_zero) begin
            r_tile  <= w_tile_next;
            r_addr  <= r_addr + 1'b1;
            r_state <= (w_tile_next == r_num_tiles) ? DONE : FETCH;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_strb              = phase_strobes(r_state);
  assign rst_o               = w_strb.rst;
  assign load_o              = w_strb.load;
  assign ready_o             = w_strb.ready;
  assign start_op_o          = w_strb.start_op;
  assign rd_rom_signals_ld_o = w_strb.rom_ld;
  assign rd_weight_ld_o      = w_strb.weight_ld;
  assign rd_feature_ld_o     = w_strb.start_op & feat_valid_i;
  assign busy_o              = w_strb.busy;
  assign done_o              = w_strb.done;
  assign addrs_rom_signal_o  = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_sa_phase_sequencer.sv
// ============================================================================
// Module      : tb_sa_phase_sequencer
// Description : Directed self-checking bench for sa_phase_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_phase_sequencer;

  logic        clk_i;
  logic        general_rst_i;
  logic        start_i;
  logic        abort_i;
  logic [9:0]  num_tiles_i;
  logic [9:0]  rom_base_i;
  logic [15:0] load_cycles_i;
  logic [15:0] op_cycles_i;
  logic        feat_valid_i;
  logic        rst_o, load_o, ready_o, start_op_o;
  logic        rd_rom_signals_ld_o, rd_weight_ld_o, rd_feature_ld_o;
  logic [9:0]  addrs_rom_signal_o;
  logic        busy_o, done_o;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  sa_phase_sequencer dut (
    .clk_i               (clk_i),
    .general_rst_i       (general_rst_i),
    .start_i             (start_i),
    .abort_i             (abort_i),
    .num_tiles_i         (num_tiles_i),
    .rom_base_i          (rom_base_i),
    .load_cycles_i       (load_cycles_i),
    .op_cycles_i         (op_cycles_i),
    .feat_valid_i        (feat_valid_i),
    .rst_o               (rst_o),
    .load_o              (load_o),
    .ready_o             (ready_o),
    .start_op_o          (start_op_o),
    .rd_rom_signals_ld_o (rd_rom_signals_ld_o),
    .rd_weight_ld_o      (rd_weight_ld_o),
    .rd_feature_ld_o     (rd_feature_ld_o),
    .addrs_rom_signal_o  (addrs_rom_signal_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // {rst, load, ready, start_op, rom_ld, weight_ld, feature_ld, busy, done}
  logic [8:0] obs_vec;
  assign obs_vec = {rst_o, load_o, ready_o, start_op_o, rd_rom_signals_ld_o,
                    rd_weight_ld_o, rd_feature_ld_o, busy_o, done_o};

  // Phase letters: R reset, F fetch, L load, Y ready, O operate, D done, I idle.
  function automatic logic [8:0] phase_vec(input byte ch, input logic fv);
    logic [8:0] v;
    v = '0;
    case (ch)
      "R": begin v[8] = 1'b1; v[1] = 1'b1; end
      "F": begin v[4] = 1'b1; v[1] = 1'b1; end
      "L": begin v[7] = 1'b1; v[3] = 1'b1; v[1] = 1'b1; end
      "Y": begin v[6] = 1'b1; v[1] = 1'b1; end
      "O": begin v[5] = 1'b1; v[2] = fv; v[1] = 1'b1; end
      "D": begin v[0] = 1'b1; v[1] = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int tiles, input int base, input int lc, input int oc);
    chk("idle_before_start", {31'd0, busy_o}, 32'd0);
    num_tiles_i   = 10'(tiles);
    rom_base_i    = 10'(base);
    load_cycles_i = 16'(lc);
    op_cycles_i   = 16'(oc);
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    num_tiles_i   = '1;
    rom_base_i    = '1;
    load_cycles_i = '1;
    op_cycles_i   = '1;
  endtask

  // Walks one cycle per letter starting in cycle 1; checks FETCH addresses in order.
  task automatic run_seq(input string tag, input string seq, input int fa0, input int fa1);
    int  nf;
    byte ch;
    nf = 0;
    for (int i = 0; i < seq.len(); i++) begin
      ch = seq[i];
      chk($sformatf("%s_c%0d_%c", tag, i + 1, ch), {23'd0, obs_vec},
          {23'd0, phase_vec(ch, feat_valid_i)});
      if (ch == "F") begin
        chk($sformatf("%s_addr%0d", tag, nf), {22'd0, addrs_rom_signal_o},
            32'(nf == 0 ? fa0 : fa1));
        nf++;
      end
      tick();
    end
  endtask

  int feat_cnt;
  int done_cyc;
  int done_seen;

  initial begin
    general_rst_i = 1'b1;
    start_i       = 1'b0;
    abort_i       = 1'b0;
    feat_valid_i  = 1'b1;
    num_tiles_i   = '0;
    rom_base_i    = '0;
    load_cycles_i = '0;
    op_cycles_i   = '0;
    tick();
    tick();
    chk("reset_outputs", {23'd0, obs_vec}, 32'd0);
    chk("reset_addr", {22'd0, addrs_rom_signal_o}, 32'd0);
    general_rst_i = 1'b0;
    tick();

    // Nominal two-tile job.
    start_job(2, 5, 3, 4);
    run_seq("nominal", "RRFLLLYOOOOFLLLYOOOOD", 5, 6);
    chk("idle_holds_addr", {22'd0, addrs_rom_signal_o}, 32'd7);

    // Back-to-back start in first IDLE cycle, with a 3-cycle feature stall.
    start_job(2, 5, 3, 4);
    feat_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 26; c++) begin
      feat_valid_i = !(c >= 9 && c <= 11);
      #1;
      if (rd_feature_ld_o) feat_cnt++;
      if (done_o) done_cyc = c;
      tick();
    end
    feat_valid_i = 1'b1;
    chk("stall_done_cycle", 32'(done_cyc), 32'd24);
    chk("stall_feat_count", 32'(feat_cnt), 32'd8);

    // Zero tiles.
    start_job(0, 9, 3, 4);
    run_seq("zero_tiles", "RRDI", 9, 9);

    // Abort during LOAD in cycle 5.
    start_job(2, 5, 3, 4);
    run_seq("abort", "RRFL", 5, 6);
    chk("abort_c5_load", {23'd0, obs_vec}, {23'd0, phase_vec("L", 1'b1)});
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    done_seen = 0;
    chk("abort_c6_reset", {23'd0, obs_vec}, {23'd0, phase_vec("R", 1'b1)});
    tick();
    for (int c = 7; c <= 12; c++) begin
      if (done_o || busy_o) done_seen++;
      tick();
    end
    chk("abort_quiet_after", 32'(done_seen), 32'd0);

    // Asynchronous reset in the middle of RUN.
    start_job(2, 5, 3, 4);
    run_seq("pre_rst", "RRFLLLYO", 5, 6);
    general_rst_i = 1'b1;
    #1;
    chk("midrun_rst_outputs", {23'd0, obs_vec}, 32'd0);
    chk("midrun_rst_addr", {22'd0, addrs_rom_signal_o}, 32'd0);
    #1;
    general_rst_i = 1'b0;
    tick();
    start_job(1, 77, 1, 1);
    run_seq("post_rst", "RRFLYOD", 77, 77);

    // Zero-length phases and address wrap.
    start_job(2, 1023, 0, 0);
    run_seq("wrap", "RRFLYOFLYOD", 1023, 0);
    chk("wrap_idle", {23'd0, obs_vec}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
